// File: rtl/tcp_tx_sender.sv
// Single-request TCP transmit sequencer: meta issue, status/backoff retry, payload pass-through or drain.
// Define TCP_TX_SENDER_STATS_EN to add the stat_pkts/stat_retries/stat_drops counters.
module tcp_tx_sender #(
   parameter int MAX_RETRIES    = 8,
   parameter int BACKOFF_CYCLES = 64
) (
   input  logic         aclk,
   input  logic         areset,
   input  logic         s_tx_req_valid,
   output logic         s_tx_req_ready,
   input  logic [31:0]  s_tx_req_data,
   output logic         m_tcp_tx_meta_valid,
   input  logic         m_tcp_tx_meta_ready,
   output logic [31:0]  m_tcp_tx_meta_data,
   input  logic         s_tcp_tx_stat_valid,
   output logic         s_tcp_tx_stat_ready,
   input  logic [63:0]  s_tcp_tx_stat_data,
   input  logic         s_axis_tx_tvalid,
   output logic         s_axis_tx_tready,
   input  logic [511:0] s_axis_tx_tdata,
   input  logic [63:0]  s_axis_tx_tkeep,
   input  logic         s_axis_tx_tlast,
   output logic         m_axis_tx_tvalid,
   input  logic         m_axis_tx_tready,
   output logic [511:0] m_axis_tx_tdata,
   output logic [63:0]  m_axis_tx_tkeep,
   output logic         m_axis_tx_tlast,
   output logic         m_tx_done_valid,
   input  logic         m_tx_done_ready,
   output logic [31:0]  m_tx_done_data
`ifdef TCP_TX_SENDER_STATS_EN
   ,
   output logic [31:0]  stat_pkts,
   output logic [31:0]  stat_retries,
   output logic [31:0]  stat_drops
`endif
);

   localparam int BW = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
   localparam logic [BW-1:0] BO_LAST = BW'(BACKOFF_CYCLES - 1);
   localparam logic [7:0] MAX_R = 8'(MAX_RETRIES);

   typedef enum logic [2:0] {IDLE, META, STAT, DATA, BACKOFF, DRAIN, DONE} state_t;

   state_t      state;
   logic [15:0] sid;
   logic [15:0] len;
   logic [10:0] beats;
   logic [10:0] beat_cnt;
   logic [7:0]  retries;
   logic [1:0]  code;
   logic [BW-1:0] bo_cnt;
   logic        run;
   logic        last_beat;
   logic [16:0] len_rnd;
   logic [1:0]  err;
   logic        unused_ok;

   // Handshake outputs are forced low while reset is held.
   assign run       = !areset;
   assign err       = s_tcp_tx_stat_data[63:62];
   assign len_rnd   = {1'b0, s_tx_req_data[31:16]} + 17'd63;
   assign last_beat = (beat_cnt == beats - 11'd1);
   assign unused_ok = ^{s_axis_tx_tlast, s_tcp_tx_stat_data[61:0]};

   assign s_tx_req_ready      = run && (state == IDLE);
   assign m_tcp_tx_meta_valid = run && (state == META);
   assign m_tcp_tx_meta_data  = {len, sid};
   assign s_tcp_tx_stat_ready = run && (state == STAT);
   assign m_axis_tx_tvalid    = run && (state == DATA) && s_axis_tx_tvalid;
   assign s_axis_tx_tready    = run && (((state == DATA) && m_axis_tx_tready) || (state == DRAIN));
   assign m_axis_tx_tdata     = s_axis_tx_tdata;
   assign m_axis_tx_tkeep     = s_axis_tx_tkeep;
   assign m_axis_tx_tlast     = (state == DATA) && last_beat;
   assign m_tx_done_valid     = run && (state == DONE);
   assign m_tx_done_data      = {6'd0, retries, code, sid};

   always_ff @(posedge aclk) begin
      if (areset) begin
         state    <= IDLE;
         beat_cnt <= '0;
         retries  <= '0;
         bo_cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (s_tx_req_valid) begin
               sid      <= s_tx_req_data[15:0];
               len      <= s_tx_req_data[31:16];
               beats    <= len_rnd[16:6];
               beat_cnt <= '0;
               retries  <= '0;
               if (s_tx_req_data[31:16] == 16'd0) begin
                  code  <= 2'd3;
                  state <= DONE;
               end else begin
                  state <= META;
               end
            end
            META: if (m_tcp_tx_meta_ready) state <= STAT;
            STAT: if (s_tcp_tx_stat_valid) begin
               beat_cnt <= '0;
               case (err)
                  2'd0: state <= DATA;
                  2'd1: begin
                     if (retries == MAX_R) begin
                        code  <= 2'd1;
                        state <= DONE;
                     end else begin
                        bo_cnt <= '0;
                        state  <= BACKOFF;
                     end
                  end
                  default: begin
                     code  <= 2'd2;
                     state <= DRAIN;
                  end
               endcase
            end
            BACKOFF: begin
               if (bo_cnt == BO_LAST) begin
                  bo_cnt  <= '0;
                  retries <= (retries == 8'hFF) ? retries : retries + 8'd1;
                  state   <= META;
               end else begin
                  bo_cnt <= bo_cnt + 1'b1;
               end
            end
            DATA: if (s_axis_tx_tvalid && m_axis_tx_tready) begin
               if (last_beat) begin
                  code  <= 2'd0;
                  state <= DONE;
               end else begin
                  beat_cnt <= beat_cnt + 11'd1;
               end
            end
            // The stack refused the connection; swallow exactly the announced payload.
            DRAIN: if (s_axis_tx_tvalid) begin
               if (last_beat) state <= DONE;
               else           beat_cnt <= beat_cnt + 11'd1;
            end
            DONE: if (m_tx_done_ready) begin
               retries <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef TCP_TX_SENDER_STATS_EN
   always_ff @(posedge aclk) begin
      if (areset) begin
         stat_pkts    <= '0;
         stat_retries <= '0;
         stat_drops   <= '0;
      end else if (state == DONE && m_tx_done_ready) begin
         if (code == 2'd0) stat_pkts  <= stat_pkts + 32'd1;
         else              stat_drops <= stat_drops + 32'd1;
         stat_retries <= stat_retries + 32'(retries);
      end
   end
`endif

endmodule

// File: tb/tb_tcp_tx_sender.sv
// Randomized bench for tcp_tx_sender: transaction-level expectations per request, per-cycle compare.
module tb_tcp_tx_sender;
   localparam int MAXR = 8;
   localparam int BO   = 64;

   logic         aclk = 1'b0;
   logic         areset;
   logic         s_tx_req_valid, s_tx_req_ready;
   logic [31:0]  s_tx_req_data;
   logic         m_tcp_tx_meta_valid, m_tcp_tx_meta_ready;
   logic [31:0]  m_tcp_tx_meta_data;
   logic         s_tcp_tx_stat_valid, s_tcp_tx_stat_ready;
   logic [63:0]  s_tcp_tx_stat_data;
   logic         s_axis_tx_tvalid, s_axis_tx_tready, s_axis_tx_tlast;
   logic [511:0] s_axis_tx_tdata;
   logic [63:0]  s_axis_tx_tkeep;
   logic         m_axis_tx_tvalid, m_axis_tx_tready, m_axis_tx_tlast;
   logic [511:0] m_axis_tx_tdata;
   logic [63:0]  m_axis_tx_tkeep;
   logic         m_tx_done_valid, m_tx_done_ready;
   logic [31:0]  m_tx_done_data;

   tcp_tx_sender #(.MAX_RETRIES(MAXR), .BACKOFF_CYCLES(BO)) dut (
      .aclk(aclk), .areset(areset),
      .s_tx_req_valid(s_tx_req_valid), .s_tx_req_ready(s_tx_req_ready), .s_tx_req_data(s_tx_req_data),
      .m_tcp_tx_meta_valid(m_tcp_tx_meta_valid), .m_tcp_tx_meta_ready(m_tcp_tx_meta_ready),
      .m_tcp_tx_meta_data(m_tcp_tx_meta_data),
      .s_tcp_tx_stat_valid(s_tcp_tx_stat_valid), .s_tcp_tx_stat_ready(s_tcp_tx_stat_ready),
      .s_tcp_tx_stat_data(s_tcp_tx_stat_data),
      .s_axis_tx_tvalid(s_axis_tx_tvalid), .s_axis_tx_tready(s_axis_tx_tready),
      .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tkeep(s_axis_tx_tkeep), .s_axis_tx_tlast(s_axis_tx_tlast),
      .m_axis_tx_tvalid(m_axis_tx_tvalid), .m_axis_tx_tready(m_axis_tx_tready),
      .m_axis_tx_tdata(m_axis_tx_tdata), .m_axis_tx_tkeep(m_axis_tx_tkeep), .m_axis_tx_tlast(m_axis_tx_tlast),
      .m_tx_done_valid(m_tx_done_valid), .m_tx_done_ready(m_tx_done_ready), .m_tx_done_data(m_tx_done_data)
   );

   always #5 aclk = ~aclk;

   int checks = 0, errors = 0;

   // Stimulus for the current request, indexed by how far the DUT has consumed it.
   logic [511:0] ub_data [0:31];
   logic [63:0]  ub_keep [0:31];
   logic         ub_last [0:31];
   int           ub_n = 0;
   logic [63:0]  st [0:15];
   int           st_n = 0;
   int           rdy_pct = 70;

   // Observed progress (written by the compare process).
   int consumed = 0, stat_taken = 0, meta_seen = 0, out_cnt = 0, req_cnt = 0, tlast_cnt = 0;
   int cyc = 0, last_meta_cyc = 0;
   bit done_seen = 0, data_phase = 0, req_prev = 0;
   logic [1:0]  data_err = 2'd0;
   logic [31:0] last_done = '0, last_meta = '0;

   // Expectations for the current request.
   int exp_metas = 0, exp_consume = 0, exp_out = 0;
   logic [31:0] exp_meta = '0, exp_done = '0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic flag(input string name, input bit bad, input int act, input int req);
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   always @(negedge aclk) begin
      cyc++;
      if (areset) begin
         chk("reset_quiet", {s_tx_req_ready, m_tcp_tx_meta_valid, s_tcp_tx_stat_ready,
                             s_axis_tx_tready, m_axis_tx_tvalid, m_tx_done_valid}, '0);
         req_prev = 0;
      end else begin
         if (req_cnt > 0 && !done_seen) chk("one_in_flight", s_tx_req_ready, 1'b0);
         if (req_prev) begin
            if (exp_metas > 0) chk("req_to_meta_latency", m_tcp_tx_meta_valid, 1'b1);
            else               chk("zero_len_done_latency", m_tx_done_valid, 1'b1);
         end
         req_prev = s_tx_req_valid && s_tx_req_ready;
         if (req_prev) req_cnt++;
         if (m_tcp_tx_meta_valid) begin
            chk("meta_data", m_tcp_tx_meta_data, exp_meta);
            if (m_tcp_tx_meta_ready) begin
               meta_seen++;
               last_meta = m_tcp_tx_meta_data;
               if (meta_seen > 1)
                  flag("meta_spacing", (cyc - last_meta_cyc - 1) < BO, cyc - last_meta_cyc - 1, BO);
               last_meta_cyc = cyc;
               flag("extra_meta", meta_seen > exp_metas, meta_seen, exp_metas);
            end
         end
         if (s_axis_tx_tvalid && s_axis_tx_tready) begin
            flag("user_consume", !data_phase || consumed >= exp_consume, consumed + 1, exp_consume);
            consumed++;
         end
         if (m_axis_tx_tvalid) begin
            checks++;
            if (!data_phase || data_err != 2'd0 || out_cnt >= exp_out) begin
               errors++;
               $display("FAIL out_unexpected: beat %0d while %0d expected", out_cnt, exp_out);
            end else begin
               chk("out_tdata", m_axis_tx_tdata, ub_data[out_cnt]);
               chk("out_tkeep", m_axis_tx_tkeep, ub_keep[out_cnt]);
               chk("out_tlast", m_axis_tx_tlast, out_cnt == exp_out - 1);
            end
            if (m_axis_tx_tready) begin
               if (m_axis_tx_tlast) tlast_cnt++;
               out_cnt++;
            end
         end
         if (s_tcp_tx_stat_valid && s_tcp_tx_stat_ready) begin
            stat_taken++;
            if (s_tcp_tx_stat_data[63:62] != 2'd1) begin
               data_phase = 1;
               data_err   = s_tcp_tx_stat_data[63:62];
            end
         end
         if (m_tx_done_valid) begin
            chk("done_data", m_tx_done_data, exp_done);
            if (m_tx_done_ready) begin
               flag("dup_done", done_seen, 2, 1);
               done_seen = 1;
               last_done = m_tx_done_data;
            end
         end
      end
   end

   task automatic drive();
      @(posedge aclk);
      #1;
      if (req_cnt > 0) s_tx_req_valid = 1'b0;
      if (stat_taken < st_n) begin
         s_tcp_tx_stat_valid = ($urandom_range(0, 3) != 0);
         s_tcp_tx_stat_data  = st[stat_taken];
      end else begin
         s_tcp_tx_stat_valid = 1'b0;
      end
      if (consumed < ub_n) begin
         s_axis_tx_tvalid = ($urandom_range(0, 4) != 0);
         s_axis_tx_tdata  = ub_data[consumed];
         s_axis_tx_tkeep  = ub_keep[consumed];
         s_axis_tx_tlast  = ub_last[consumed];
      end else begin
         s_axis_tx_tvalid = 1'b0;
      end
      m_axis_tx_tready    = ($urandom_range(0, 99) < rdy_pct);
      m_tcp_tx_meta_ready = ($urandom_range(0, 2) != 0);
      m_tx_done_ready     = ($urandom_range(0, 2) != 0);
   endtask

   task automatic clear_progress();
      consumed = 0; stat_taken = 0; meta_seen = 0; out_cnt = 0; req_cnt = 0; tlast_cnt = 0;
      done_seen = 0; data_phase = 0; data_err = 2'd0; req_prev = 0;
   endtask

   // nerr1 > MAXR means the stack answers "no space" forever.
   task automatic start_req(input logic [15:0] sid, input logic [15:0] len, input int nerr1, input logic [1:0] ferr);
      int beats, code, retr, n1;
      bit abort;
      beats = (int'(len) + 63) / 64;
      abort = (nerr1 > MAXR);
      n1    = abort ? MAXR + 1 : nerr1;
      if (len == 16'd0) begin
         exp_metas = 0; code = 3; retr = 0; exp_consume = 0; exp_out = 0;
      end else if (abort) begin
         exp_metas = MAXR + 1; code = 1; retr = MAXR; exp_consume = 0; exp_out = 0;
      end else begin
         exp_metas = nerr1 + 1; retr = nerr1; code = (ferr == 2'd0) ? 0 : 2;
         exp_consume = beats; exp_out = (ferr == 2'd0) ? beats : 0;
      end
      st_n = 0;
      if (len != 16'd0) begin
         for (int i = 0; i < n1; i++) st[i] = {2'b01, 30'($urandom), $urandom};
         st_n = n1;
         if (!abort) begin
            st[n1] = {ferr, 30'($urandom), $urandom};
            st_n = n1 + 1;
         end
      end
      ub_n = exp_consume + $urandom_range(0, 2);
      for (int i = 0; i < ub_n; i++) begin
         for (int w = 0; w < 16; w++) ub_data[i][w*32 +: 32] = $urandom;
         ub_keep[i] = {$urandom, $urandom};
         ub_last[i] = 1'($urandom);
      end
      exp_meta = {len, sid};
      exp_done = {6'd0, 8'(retr), 2'(code), sid};
      clear_progress();
      s_tx_req_data  = {len, sid};
      s_tx_req_valid = 1'b1;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done_seen && n < 3000) begin
         drive();
         n++;
      end
      flag({name, "_timeout"}, !done_seen, n, 3000);
      flag({name, "_metas"}, meta_seen != exp_metas, meta_seen, exp_metas);
      flag({name, "_consumed"}, consumed != exp_consume, consumed, exp_consume);
      flag({name, "_out_beats"}, out_cnt != exp_out, out_cnt, exp_out);
      flag({name, "_tlast_count"}, tlast_cnt != ((exp_out > 0) ? 1 : 0), tlast_cnt, (exp_out > 0) ? 1 : 0);
      flag({name, "_stat_taken"}, stat_taken != st_n, stat_taken, st_n);
   endtask

   task automatic check_idle_outputs(input string name);
      chk(name, {s_tx_req_ready, m_tcp_tx_meta_valid, s_tcp_tx_stat_ready,
                 s_axis_tx_tready, m_axis_tx_tvalid, m_tx_done_valid}, 6'b100000);
   endtask

   initial begin
      int n;
      areset = 1'b1;
      s_tx_req_valid = 1'b0; s_tx_req_data = '0;
      m_tcp_tx_meta_ready = 1'b0;
      s_tcp_tx_stat_valid = 1'b0; s_tcp_tx_stat_data = '0;
      s_axis_tx_tvalid = 1'b0; s_axis_tx_tdata = '0; s_axis_tx_tkeep = '0; s_axis_tx_tlast = 1'b0;
      m_axis_tx_tready = 1'b0; m_tx_done_ready = 1'b0;
      repeat (3) drive();
      areset = 1'b0;
      #1;
      check_idle_outputs("after_reset");

      start_req(16'd5, 16'd200, 0, 2'd0);
      wait_done("basic");
      chk("basic_meta_word", last_meta, 32'h00C80005);
      chk("basic_done_word", last_done, 32'h00000005);
      flag("basic_four_beats", out_cnt != 4, out_cnt, 4);

      start_req(16'd7, 16'd64, 2, 2'd0);
      wait_done("retry2");
      flag("retry2_three_metas", meta_seen != 3, meta_seen, 3);
      chk("retry2_done_word", last_done, 32'h00080007);

      start_req(16'd9, 16'd128, 0, 2'd2);
      wait_done("noconn");
      flag("noconn_drained", consumed != 2, consumed, 2);
      chk("noconn_done_word", last_done, 32'h00020009);

      start_req(16'd3, 16'd0, 0, 2'd0);
      wait_done("zerolen");
      chk("zerolen_done_word", last_done, 32'h00030003);

      start_req(16'h11, 16'd100, MAXR + 1, 2'd0);
      wait_done("abort");
      flag("abort_nine_metas", meta_seen != 9, meta_seen, 9);
      chk("abort_done_word", last_done, 32'h00210011);

      for (int k = 0; k < 14; k++) begin
         logic [15:0] rl;
         int ne;
         logic [1:0] fe;
         rdy_pct = $urandom_range(30, 100);
         case ($urandom_range(0, 5))
            0:       rl = 16'd0;
            1:       rl = 16'(64 * $urandom_range(1, 16));
            default: rl = 16'($urandom_range(1, 1024));
         endcase
         ne = ($urandom_range(0, 9) == 0) ? MAXR + 1 : $urandom_range(0, 2);
         case ($urandom_range(0, 3))
            0:       fe = 2'd2;
            1:       fe = 2'd3;
            default: fe = 2'd0;
         endcase
         start_req(16'($urandom), rl, ne, fe);
         wait_done("random");
      end

      // Reset in the middle of a 10-beat packet under random back-pressure.
      rdy_pct = 50;
      start_req(16'h22, 16'd640, 0, 2'd0);
      n = 0;
      while (out_cnt < 5 && n < 2000) begin
         drive();
         n++;
      end
      flag("midpkt_reach", out_cnt < 5, out_cnt, 5);
      areset = 1'b1;
      repeat (2) drive();
      flag("midpkt_no_loss", consumed != out_cnt, out_cnt, consumed);
      flag("midpkt_no_tlast", tlast_cnt != 0, tlast_cnt, 0);
      drive();
      areset = 1'b0;
      s_tx_req_valid = 1'b0;
      ub_n = 0; st_n = 0; exp_metas = 0;
      clear_progress();
      s_axis_tx_tvalid = 1'b0;
      s_tcp_tx_stat_valid = 1'b0;
      #1;
      check_idle_outputs("midpkt_after_reset");

      rdy_pct = 80;
      start_req(16'h33, 16'd130, 1, 2'd0);
      wait_done("recovery");
      chk("recovery_done_word", last_done, 32'h00040033);

      repeat (4) drive();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/tcp_tx_sender.md
TCP_TX_SENDER -- requirements
Module: tcp_tx_sender

Interface
REQ-001 SHALL have parameter MAX_RETRIES, default 8: no-space retries per request before abort.
REQ-002 SHALL have parameter BACKOFF_CYCLES, default 64: idle cycles between retries.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all logic is on this clock.
REQ-004 SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port s_tx_req, metaIntf slave, 32-bit data: user send request; sid [15:0], len in bytes [31:16].
REQ-006 SHALL have port m_tcp_tx_meta, metaIntf master, 32-bit data: tx meta toward the clock crossing; sid [15:0], len [31:16].
REQ-007 SHALL have port s_tcp_tx_stat, metaIntf slave, 64-bit data: stack status; sid [15:0], len [31:16], space [61:32], err [63:62].
REQ-008 SHALL have port s_axis_tx, AXI4S slave, 512/64/1 bits: user payload (tdata, tkeep, tlast).
REQ-009 SHALL have port m_axis_tx, AXI4S master, 512/64/1 bits: payload toward the clock crossing.
REQ-010 SHALL have port m_tx_done, metaIntf master, 32-bit data: completion; sid [15:0], code [17:16] (0 ok, 1 no-space abort, 2 no-connection, 3 zero length), retries [25:18].

Function
REQ-011 SHALL implement states IDLE, META, STAT, DATA, BACKOFF, DRAIN, DONE.
REQ-012 IDLE: s_tx_req.ready=1; on accept, register sid and len, and compute beats=ceil(len/64) as 11 bits; len=0 -> DONE with code 3.
REQ-013 META: m_tcp_tx_meta.valid=1 holding the registered sid/len; on ready -> STAT; data SHALL be stable while valid.
REQ-014 STAT: s_tcp_tx_stat.ready=1; err=0 -> DATA; err=1 -> BACKOFF, or DONE with code 1 if retries==MAX_RETRIES; err=2 or 3 -> DRAIN with code 2.
REQ-015 Returned sid/len in the status are not checked; status words are consumed in order.
REQ-016 BACKOFF: SHALL count BACKOFF_CYCLES, then increment retries (8-bit saturating) -> META; no request or data is accepted.
REQ-017 DATA: m_axis_tx.tvalid=s_axis_tx.tvalid, s_axis_tx.tready=m_axis_tx.tready, with tdata/tkeep passed through combinationally.
REQ-018 In DATA, a beat counter SHALL increment per transfer; m_axis_tx.tlast=1 on beat beats-1 regardless of the user tlast; after that beat -> DONE with code 0.
REQ-019 DRAIN: s_axis_tx.tready=1 and m_axis_tx.tvalid=0; exactly beats beats are discarded, then -> DONE.
REQ-020 DONE: m_tx_done.valid=1; on ready -> IDLE, and retries is cleared.
REQ-021 No user data SHALL be consumed outside DATA/DRAIN; the user stream may be presented early and stalls.
REQ-022 Throughput in DATA SHALL be one beat per cycle with zero added latency; request-to-first-meta latency is 1 cycle.
REQ-023 Exactly one request SHALL be in flight at a time.

Reset
REQ-024 On areset the block SHALL go to IDLE; counters and retries are cleared.
REQ-025 During and after reset all valid/ready outputs SHALL be 0, except s_tx_req.ready=1 from the first cycle after reset.
REQ-026 A reset mid-DATA SHALL abandon the packet with no tlast emitted; recovery is the upstream's responsibility.

Configuration
REQ-027 With TCP_TX_SENDER_STATS_EN defined, the block SHALL provide 32-bit outputs stat_pkts, stat_retries and stat_drops (wrapping, reset 0), incrementing in DONE on accept per code/retry event.
REQ-028 Without TCP_TX_SENDER_STATS_EN, those ports and counters SHALL be absent and the behaviour is otherwise identical.

Verification
REQ-029 Request sid=5, len=200, stat err=0, then 4 user beats -> meta 0x00C80005; 4 output beats with tlast on beat 4; done 0x00000005.
REQ-030 Request len=64, stat err=1 twice then err=0 -> 3 metas each spaced >=64 idle cycles; 1 beat out; done code 0, retries 2.
REQ-031 Request len=128, stat err=2 -> no output beats; 2 user beats consumed; done code 2.
REQ-032 Request len=0 -> no meta issued; done code 3 on the next cycle.
REQ-033 MAX_RETRIES=8 with err=1 repeated -> 9 metas; done code 1, retries 8; user data untouched.
REQ-034 m_axis_tx.tready toggled randomly during a 10-beat packet, and areset asserted mid-packet -> no beat lost or duplicated; after reset, state is IDLE with all valids 0.
